operand_fetch_seq: RTL and testbench
====================================

Name: operand_fetch_seq

Overview:
- Parametrised operand-fetch sequencer for the MSP430 core; it replaces the control-driven operand latch set with a self-sequencing FSM.
- Decodes As/Ad source and destination addressing and fetches extension words through PC.
- Issues memory reads with a handshake, generates constant-generator values and autoincrement write-backs, and presents both operands plus the destination address to the execute stage.
- Sits between the decode stage and the function unit, sharing the memory bus.

Parameters:
- ADDR_W, 16, memory address width; 20 reserved for the extended address space. Address arithmetic is modulo 2^ADDR_W.
- USE_CG, 1, enables the constant generator (R2/R3). When 0, R2/R3 are treated as normal registers.
- ACK_TIMEOUT, 15, maximum wait cycles for mem_ack before abort. Range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin fetch for the decoded instruction. Sampled only in IDLE.
- flush  in  1  synchronous abort to IDLE.
- as  in  2  source addressing mode.
- ad  in  1  destination addressing mode.
- src_reg  in  4  source register number.
- dst_reg  in  4  destination register number.
- byte_op  in  1  byte instruction.
- dst_rd_en  in  1  destination memory operand must be read (0 for MOV).
- rsrc  in  16  register-file value of src_reg.
- rdst  in  16  register-file value of dst_reg.
- pc_in  in  ADDR_W  current PC; already updated the cycle after pc_inc.
- mdb  in  16  memory data bus.
- mem_ack  in  1  read data valid on mdb this cycle.
- mab  out  ADDR_W  memory address.
- mem_rd  out  1  read request.
- pc_inc  out  1  one-cycle pulse: PC += 2.
- ai_wr  out  1  one-cycle autoincrement write-back pulse.
- ai_reg  out  4  register written by ai_wr.
- ai_data  out  16  autoincremented value.
- op_src  out  16  source operand.
- op_dst  out  16  destination operand.
- dst_addr  out  ADDR_W  destination effective address; 0 when Ad=0.
- ops_valid  out  1  operands ready. Held until ops_taken.
- ops_taken  in  1  execute stage consumed operands.
- busy  out  1  state != IDLE.
- err  out  1  one-cycle pulse on ack timeout.

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs 0: mab, op_src, op_dst, dst_addr, ai_*, and all strobes.
- States and order: IDLE -> S_EXT -> S_RD -> D_EXT -> D_RD -> VALID -> IDLE. Unneeded states are skipped.
- Source modes:
  - As=00: op_src=rsrc, no memory cycle.
  - As=01: S_EXT fetches X at pc_in and pulses pc_inc; then S_RD reads at X+rsrc. If src_reg=R2 and USE_CG=1, reads at X (absolute).
  - As=10: S_RD reads at rsrc.
  - As=11: S_RD reads at rsrc and pulses ai_wr (ai_reg=src_reg, ai_data=rsrc+inc). inc=1 if byte_op and src_reg!=R1, else 2.
  - As=11 with src_reg=R0 (immediate): reads at pc_in, pulses pc_inc, no ai_wr.
- Constant generator (USE_CG=1, no memory cycle):
  - R3: As 00/01/10/11 -> 0, 1, 2, 16'hFFFF.
  - R2: As=10 -> 4; As=11 -> 8.
- Destination modes:
  - Ad=0: op_dst=rdst.
  - Ad=1: D_EXT fetches Y (pc_inc pulse); dst_addr=Y+rdst, or Y when dst_reg=R2. D_RD reads only if dst_rd_en=1, else op_dst=0.
- Memory handshake:
  - mem_rd and mab are held stable until the cycle mem_ack=1; data is captured that cycle.
  - pc_inc and ai_wr pulse in the ack cycle.
  - Minimum one cycle per memory state.
- Byte operands: op = zero-extended mdb[7:0] for even addresses, mdb[15:8] for odd. Extension words are always full 16-bit.
- Register-mode byte ops: operand = {8'h00, reg[7:0]}.
- Timeout:
  - Wait counter resets on entry to each memory state.
  - If ACK_TIMEOUT cycles pass without ack: err pulse, return to IDLE, no pc_inc, no ai_wr, no ops_valid.
- Latency:
  - Register/register: ops_valid is asserted the cycle after start.
  - Each memory state adds ≥1 cycle.
- VALID: ops_valid=1 until ops_taken; same cycle -> IDLE. A start in that cycle is ignored.
- start while busy is ignored.
- flush has priority over mem_ack: the FSM goes to IDLE, all strobes are suppressed, and operand registers retain their values.
- Reset mid-operation aborts immediately with no strobes.

Test Plan:
- MOV R5,R6 (as=00, ad=0), rsrc=16'h1234, rdst=16'h0055 -> ops_valid the cycle after start, op_src=1234, op_dst=0055, no mem_rd.
- ADD 4(R4),&0x0200 (as=01, ad=1, dst_reg=R2), pc_in=C000, mdb X=0004, rsrc=0300, Y=0200, 1-cycle acks -> mab sequence C000, 0304, C002, 0200; two pc_inc pulses; dst_addr=0200.
- MOV.B @R7+ (as=11), rsrc=0301, mdb=ABCD -> op_src=00AB, ai_wr with ai_reg=7, ai_data=0302. Repeat with src_reg=R1 -> ai_data=rsrc+2.
- Constant generator: src R3 as=11 -> op_src=FFFF; src R2 as=11 -> 0008; no mem_rd in either case.
- Timeout: as=10, mem_ack held 0 -> err pulse after 15 wait cycles, FSM in IDLE, no ops_valid.
- flush asserted the same cycle as mem_ack in S_RD with as=11 -> no ai_wr, IDLE next cycle. rst low mid-D_EXT -> all outputs 0 immediately.

Source files
------------

// File: rtl/operand_fetch_seq.sv
// operand_fetch_seq: MSP430 operand-fetch sequencer; decodes As/Ad, fetches extension words and memory
// operands through a handshake, and hands both operands plus the destination address to execute.
module operand_fetch_seq #(
  parameter int ADDR_W      = 16,
  parameter bit USE_CG      = 1,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              flush,
  input  logic [1:0]        as,
  input  logic              ad,
  input  logic [3:0]        src_reg,
  input  logic [3:0]        dst_reg,
  input  logic              byte_op,
  input  logic              dst_rd_en,
  input  logic [15:0]       rsrc,
  input  logic [15:0]       rdst,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [15:0]       mdb,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mab,
  output logic              mem_rd,
  output logic              pc_inc,
  output logic              ai_wr,
  output logic [3:0]        ai_reg,
  output logic [15:0]       ai_data,
  output logic [15:0]       op_src,
  output logic [15:0]       op_dst,
  output logic [ADDR_W-1:0] dst_addr,
  output logic              ops_valid,
  input  logic              ops_taken,
  output logic              busy,
  output logic              err
);
  typedef enum logic [2:0] {IDLE, S_EXT, S_RD, D_EXT, D_RD, VALID} state_t;
  state_t state, nxt;
  logic [1:0]        as_q;
  logic              ad_q, byte_q, rd_q;
  logic [3:0]        src_q, dst_q;
  logic [15:0]       x_q;
  logic [7:0]        wcnt;
  logic              mem_st, tmo, cg_in, imm, go;
  logic [15:0]       cg_val;
  logic [ADDR_W-1:0] s_addr, d_addr;

  function automatic logic [15:0] bsel(input logic [15:0] d, input logic odd, input logic b);
    return b ? {8'h00, odd ? d[15:8] : d[7:0]} : d;
  endfunction

  assign cg_in  = USE_CG && (src_reg == 4'd3 || (src_reg == 4'd2 && as[1]));
  assign cg_val = src_reg == 4'd2 ? (as[0] ? 16'd8 : 16'd4) : (as == 2'd3 ? 16'hFFFF : {14'd0, as});
  assign mem_st = state inside {S_EXT, S_RD, D_EXT, D_RD};
  assign tmo    = mem_st && !mem_ack && wcnt == 8'(ACK_TIMEOUT - 1);
  assign imm    = src_q == 4'd0 && as_q == 2'd3;
  assign go     = mem_ack && !flush;
  // R2 in indexed mode means absolute addressing: the base register contributes nothing
  assign s_addr = imm ? pc_in
                : as_q == 2'd1 ? ((USE_CG && src_q == 4'd2) ? ADDR_W'(x_q) : ADDR_W'(x_q) + ADDR_W'(rsrc))
                : ADDR_W'(rsrc);
  assign d_addr = dst_q == 4'd2 ? ADDR_W'(mdb) : ADDR_W'(mdb) + ADDR_W'(rdst);

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = !start ? IDLE : (as == 2'd1 && !cg_in) ? S_EXT : (as != 2'd0 && !cg_in) ? S_RD : ad ? D_EXT : VALID;
      S_EXT: nxt = mem_ack ? S_RD : tmo ? IDLE : S_EXT;
      S_RD:  nxt = mem_ack ? (ad_q ? D_EXT : VALID) : tmo ? IDLE : S_RD;
      D_EXT: nxt = mem_ack ? (rd_q ? D_RD : VALID) : tmo ? IDLE : D_EXT;
      D_RD:  nxt = mem_ack ? VALID : tmo ? IDLE : D_RD;
      VALID: nxt = ops_taken ? IDLE : VALID;
      default: nxt = IDLE;
    endcase
    if (flush) nxt = IDLE;
  end

  always_comb begin
    mem_rd    = mem_st;
    mab       = (state == S_EXT || state == D_EXT) ? pc_in : state == S_RD ? s_addr : state == D_RD ? dst_addr : '0;
    pc_inc    = go && (state == S_EXT || state == D_EXT || (state == S_RD && imm));
    ai_wr     = go && state == S_RD && as_q == 2'd3 && !imm;
    ai_reg    = ai_wr ? src_q : 4'd0;
    ai_data   = ai_wr ? rsrc + ((byte_q && src_q != 4'd1) ? 16'd1 : 16'd2) : 16'd0;
    ops_valid = state == VALID;
    busy      = state != IDLE;
    err       = tmo && !flush;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      as_q <= '0; ad_q <= 1'b0; byte_q <= 1'b0; rd_q <= 1'b0; src_q <= '0; dst_q <= '0;
      x_q <= '0; wcnt <= '0; op_src <= '0; op_dst <= '0; dst_addr <= '0;
    end else begin
      wcnt <= (mem_st && nxt == state) ? wcnt + 8'd1 : 8'd0;
      if (!flush) begin
        if (state == IDLE && start) begin
          as_q <= as; ad_q <= ad; src_q <= src_reg; dst_q <= dst_reg; byte_q <= byte_op; rd_q <= dst_rd_en;
          if (cg_in) op_src <= cg_val;
          else if (as == 2'd0) op_src <= bsel(rsrc, 1'b0, byte_op);
          if (!ad) begin
            op_dst   <= bsel(rdst, 1'b0, byte_op);
            dst_addr <= '0;
          end
        end
        if (state == S_EXT && mem_ack) x_q <= mdb;
        if (state == S_RD && mem_ack) op_src <= bsel(mdb, mab[0], byte_q);
        if (state == D_EXT && mem_ack) begin
          dst_addr <= d_addr;
          op_dst   <= '0;
        end
        if (state == D_RD && mem_ack) op_dst <= bsel(mdb, dst_addr[0], byte_q);
      end
    end
endmodule

// File: tb/tb_operand_fetch_seq.sv
// tb_operand_fetch_seq: directed vectors with hand-computed expectations for operand_fetch_seq.
module tb_operand_fetch_seq;
  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, flush = 1'b0, ad = 1'b0;
  logic        byte_op = 1'b0, dst_rd_en = 1'b0, mem_ack = 1'b0, ops_taken = 1'b0;
  logic [1:0]  as = '0;
  logic [3:0]  src_reg = '0, dst_reg = '0;
  logic [15:0] rsrc = '0, rdst = '0, mdb = '0, pc_in = '0;
  logic [15:0] mab, ai_data, op_src, op_dst, dst_addr;
  logic [3:0]  ai_reg;
  logic        mem_rd, pc_inc, ai_wr, ops_valid, busy, err;
  int          total = 0, bad = 0;

  operand_fetch_seq dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .as(as), .ad(ad),
    .src_reg(src_reg), .dst_reg(dst_reg), .byte_op(byte_op), .dst_rd_en(dst_rd_en),
    .rsrc(rsrc), .rdst(rdst), .pc_in(pc_in), .mdb(mdb), .mem_ack(mem_ack),
    .mab(mab), .mem_rd(mem_rd), .pc_inc(pc_inc), .ai_wr(ai_wr), .ai_reg(ai_reg),
    .ai_data(ai_data), .op_src(op_src), .op_dst(op_dst), .dst_addr(dst_addr),
    .ops_valid(ops_valid), .ops_taken(ops_taken), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic adv;
    @(posedge clk);
    #1;
  endtask

  task automatic take;
    ops_taken = 1'b1;
    adv();
    ops_taken = 1'b0;
    chk("taken_idle", busy, 0);
  endtask

  initial begin
    @(negedge clk);
    chk("rst_mab", mab, 0); chk("rst_busy", busy, 0); chk("rst_opsrc", op_src, 0);
    chk("rst_strobes", {mem_rd, pc_inc, ai_wr, ops_valid, err}, 0);
    rst = 1'b1;
    adv();
    // MOV R5,R6
    as = 2'd0; ad = 1'b0; src_reg = 4'd5; dst_reg = 4'd6; rsrc = 16'h1234; rdst = 16'h0055; start = 1'b1;
    @(negedge clk); chk("rr_nomem", mem_rd, 0);
    adv(); start = 1'b0;
    @(negedge clk);
    chk("rr_valid", ops_valid, 1); chk("rr_src", op_src, 16'h1234); chk("rr_dst", op_dst, 16'h0055);
    chk("rr_daddr", dst_addr, 0); chk("rr_nomem2", mem_rd, 0);
    take();
    // ADD 4(R4),&0x0200
    as = 2'd1; ad = 1'b1; src_reg = 4'd4; dst_reg = 4'd2; dst_rd_en = 1'b1;
    pc_in = 16'hC000; rsrc = 16'h0300; rdst = 16'h1111; start = 1'b1;
    adv(); start = 1'b0; mem_ack = 1'b1; mdb = 16'h0004;
    @(negedge clk); chk("ix_mab0", mab, 16'hC000); chk("ix_pcinc0", pc_inc, 1); chk("ix_rd0", mem_rd, 1);
    adv(); pc_in = 16'hC002; mdb = 16'h5555;
    @(negedge clk); chk("ix_mab1", mab, 16'h0304); chk("ix_pcinc1", pc_inc, 0);
    adv(); mdb = 16'h0200;
    @(negedge clk); chk("ix_mab2", mab, 16'hC002); chk("ix_pcinc2", pc_inc, 1);
    adv(); pc_in = 16'hC004; mdb = 16'h7777;
    @(negedge clk); chk("ix_mab3", mab, 16'h0200); chk("ix_pcinc3", pc_inc, 0);
    adv(); mem_ack = 1'b0;
    @(negedge clk);
    chk("ix_valid", ops_valid, 1); chk("ix_src", op_src, 16'h5555);
    chk("ix_dst", op_dst, 16'h7777); chk("ix_daddr", dst_addr, 16'h0200);
    take();
    // MOV.B @R7+
    as = 2'd3; ad = 1'b0; src_reg = 4'd7; byte_op = 1'b1; rsrc = 16'h0301; rdst = 16'h0000; start = 1'b1;
    adv(); start = 1'b0; mem_ack = 1'b1; mdb = 16'hABCD;
    @(negedge clk);
    chk("ai_mab", mab, 16'h0301); chk("ai_wr", ai_wr, 1); chk("ai_reg", ai_reg, 7);
    chk("ai_data", ai_data, 16'h0302); chk("ai_nopc", pc_inc, 0);
    adv(); mem_ack = 1'b0;
    @(negedge clk); chk("ai_src", op_src, 16'h00AB); chk("ai_valid", ops_valid, 1);
    take();
    // same with R1: increment stays 2 for the stack pointer
    src_reg = 4'd1; start = 1'b1;
    adv(); start = 1'b0; mem_ack = 1'b1;
    @(negedge clk); chk("sp_data", ai_data, 16'h0303); chk("sp_reg", ai_reg, 1);
    adv(); mem_ack = 1'b0;
    take();
    byte_op = 1'b0;
    // constant generator
    src_reg = 4'd3; as = 2'd3; start = 1'b1;
    @(negedge clk); chk("cg3_nomem", mem_rd, 0);
    adv(); start = 1'b0;
    @(negedge clk); chk("cg3_src", op_src, 16'hFFFF); chk("cg3_nomem2", mem_rd, 0); chk("cg3_valid", ops_valid, 1);
    take();
    src_reg = 4'd2; start = 1'b1;
    adv(); start = 1'b0;
    @(negedge clk); chk("cg2_src", op_src, 16'h0008); chk("cg2_nomem", mem_rd, 0);
    take();
    // timeout
    as = 2'd2; src_reg = 4'd5; rsrc = 16'h0400; start = 1'b1;
    adv(); start = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      chk($sformatf("to_err%0d", i), err, i == 15);
      chk($sformatf("to_valid%0d", i), ops_valid, 0);
      adv();
    end
    chk("to_idle", busy, 0); chk("to_noerr", err, 0); chk("to_src_kept", op_src, 16'h0008);
    // flush beats ack
    as = 2'd3; src_reg = 4'd6; rsrc = 16'h0500; start = 1'b1;
    adv(); start = 1'b0; mem_ack = 1'b1; flush = 1'b1; mdb = 16'h9999;
    @(negedge clk); chk("fl_noai", ai_wr, 0); chk("fl_noerr", err, 0);
    adv(); mem_ack = 1'b0; flush = 1'b0;
    @(negedge clk); chk("fl_idle", busy, 0); chk("fl_src_kept", op_src, 16'h0008);
    // indexed destination without read (MOV)
    as = 2'd0; ad = 1'b1; src_reg = 4'd5; dst_reg = 4'd4; dst_rd_en = 1'b0;
    rsrc = 16'h2222; rdst = 16'h0100; pc_in = 16'hC100; start = 1'b1;
    adv(); start = 1'b0; mem_ack = 1'b1; mdb = 16'h0010;
    @(negedge clk); chk("mv_mab", mab, 16'hC100); chk("mv_pcinc", pc_inc, 1);
    adv(); mem_ack = 1'b0;
    @(negedge clk);
    chk("mv_valid", ops_valid, 1); chk("mv_daddr", dst_addr, 16'h0110);
    chk("mv_dst", op_dst, 0); chk("mv_src", op_src, 16'h2222);
    take();
    // reset mid D_EXT
    start = 1'b1;
    adv(); start = 1'b0;
    @(negedge clk); chk("rm_rd", mem_rd, 1);
    #1 rst = 1'b0;
    #1;
    chk("rm_mab", mab, 0); chk("rm_busy", busy, 0); chk("rm_src", op_src, 0);
    chk("rm_daddr", dst_addr, 0); chk("rm_strobes", {mem_rd, pc_inc, ai_wr, ops_valid, err}, 0);
    adv(); rst = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
